// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: register index type, controller
// state encoding and the pending-write counter ceiling.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int NUM_REG_IDX = 1 << REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // IDLE: normal issue. FLUSH: one-cycle wrong-path squash after a taken branch.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_t;

    localparam int CNT_W_DEFAULT = 2;

    // Largest value a pending-write counter of width w may hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int CNT_MAX = (1 << CNT_W_DEFAULT) - 1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode-stage / retirement handshake bundle seen by the pipeline controller.
// master = datapath side driving ID/EX/WB status, slave = the controller.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic     ds_valid;
    reg_idx_t ds_rs1;
    reg_idx_t ds_rs2;
    logic     ds_rs1_used;
    logic     ds_rs2_used;
    reg_idx_t ds_rd;
    logic     ds_we;
    logic     ds_br_taken;
    logic     ex_allow_in;
    reg_idx_t wb_rd;
    logic     wb_we;
    logic     ds_stall;
    logic     ds_issue;
    logic     fs_flush;

    modport master (
        output ds_valid, ds_rs1, ds_rs2, ds_rs1_used, ds_rs2_used,
        output ds_rd, ds_we, ds_br_taken, ex_allow_in, wb_rd, wb_we,
        input  ds_stall, ds_issue, fs_flush
    );

    modport slave (
        input  ds_valid, ds_rs1, ds_rs2, ds_rs1_used, ds_rs2_used,
        input  ds_rd, ds_we, ds_br_taken, ex_allow_in, wb_rd, wb_we,
        output ds_stall, ds_issue, fs_flush
    );

endinterface

// File: rtl/pipe_scoreboard.sv
// Per-register pending-write counters. Issue increments, retirement
// decrements; register 0 (and any index beyond NREG) always reads zero.
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  reg_idx_t         inc_idx,
    input  logic             dec_en,
    input  reg_idx_t         dec_idx,
    input  reg_idx_t         rd_a_idx,
    output logic [CNT_W-1:0] rd_a_cnt,
    input  reg_idx_t         rd_b_idx,
    output logic [CNT_W-1:0] rd_b_cnt,
    input  reg_idx_t         full_idx,
    output logic             full
);

    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(cnt_max(CNT_W));

    // Padded to the full index space so every 5-bit index is a legal lookup.
    logic [CNT_W-1:0] cnt_arr [NUM_REG_IDX];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REG_IDX; gi++) begin : g_ent
            if (gi == 0 || gi >= NREG) begin : g_zero
                assign cnt_arr[gi] = '0;
            end else begin : g_cnt
                logic [CNT_W-1:0] cnt_reg;
                logic [CNT_W-1:0] cnt_next;
                logic             inc_req;
                logic             dec_hit;

                // Same-edge inc and dec cancel; a full counter never wraps and
                // an empty one ignores stray retirements.
                always_comb begin
                    inc_req  = inc_en && (inc_idx == reg_idx_t'(gi));
                    dec_hit  = dec_en && (dec_idx == reg_idx_t'(gi)) && (cnt_reg != '0);
                    cnt_next = cnt_reg;
                    if (inc_req && !dec_hit && (cnt_reg != CNT_MAX_V)) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end else if (dec_hit && !inc_req) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end

                // Counter register, cleared on reset to drop in-flight writes.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end

                assign cnt_arr[gi] = cnt_reg;
            end
        end
    endgenerate

    assign rd_a_cnt = cnt_arr[rd_a_idx];
    assign rd_b_cnt = cnt_arr[rd_b_idx];
    assign full     = (cnt_arr[full_idx] == CNT_MAX_V);

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: scoreboard-based RAW/WAW interlock on the
// ID stage, one-cycle fetch flush after a taken branch, stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_ctrl_if.slave        bus,
    output logic [PERF_W-1:0] stall_cycles
);

    ctrl_state_t       state_reg;
    ctrl_state_t       state_next;
    logic [PERF_W-1:0] stall_cycles_reg;
    logic [PERF_W-1:0] stall_cycles_next;

    logic [CNT_W-1:0]  rs1_cnt;
    logic [CNT_W-1:0]  rs2_cnt;
    logic              rd_full;
    logic              raw_hazard;
    logic              waw_full;
    logic              stall;
    logic              issue;
    logic              sb_inc;
    logic              sb_dec;

    pipe_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (sb_inc),
        .inc_idx  (bus.ds_rd),
        .dec_en   (sb_dec),
        .dec_idx  (bus.wb_rd),
        .rd_a_idx (bus.ds_rs1),
        .rd_a_cnt (rs1_cnt),
        .rd_b_idx (bus.ds_rs2),
        .rd_b_cnt (rs2_cnt),
        .full_idx (bus.ds_rd),
        .full     (rd_full)
    );

    // Interlock: hazards come only from registered counts, so a retirement
    // is visible to ID one cycle later (no same-cycle bypass).
    always_comb begin
        raw_hazard = (bus.ds_rs1_used && (bus.ds_rs1 != '0) && (rs1_cnt != '0)) ||
                     (bus.ds_rs2_used && (bus.ds_rs2 != '0) && (rs2_cnt != '0));
        waw_full   = bus.ds_we && (bus.ds_rd != '0) && rd_full;
        stall      = bus.ds_valid && (raw_hazard || waw_full || (state_reg == ST_FLUSH));
        issue      = bus.ds_valid && !stall && bus.ex_allow_in;
        sb_inc     = issue && bus.ds_we && (bus.ds_rd != '0);
        sb_dec     = bus.wb_we && (bus.wb_rd != '0);
    end

    // Next state: taken branch leaving ID squashes the fetch slot for one cycle.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (issue && bus.ds_br_taken) state_next = ST_FLUSH;
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Saturating count of stalled ID cycles.
    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (stall && (stall_cycles_reg != '1)) begin
            stall_cycles_next = stall_cycles_reg + PERF_W'(1);
        end
    end

    // State and performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            stall_cycles_reg <= '0;
        end else begin
            state_reg        <= state_next;
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    assign bus.ds_stall = stall;
    assign bus.ds_issue = issue;
    assign bus.fs_flush = (state_reg == ST_FLUSH);
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios followed by random traffic, each cycle compared with a
// count-per-register reference model of the interlock rules.
module tb_pipe_ctrl;

    localparam int PERF_W   = 8;
    localparam int PERF_MAX = (1 << PERF_W) - 1;
    localparam int CMAX     = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [PERF_W-1:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    int m_cnt [32];
    bit m_flush;
    int m_sc;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.PERF_W(PERF_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit we, input bit br, input bit allow);
        bus.ds_valid    = v;
        bus.ds_rs1      = 5'(rs1);
        bus.ds_rs1_used = u1;
        bus.ds_rs2      = 5'(rs2);
        bus.ds_rs2_used = u2;
        bus.ds_rd       = 5'(rd);
        bus.ds_we       = we;
        bus.ds_br_taken = br;
        bus.ex_allow_in = allow;
    endtask

    task automatic set_wb(input bit we, input int rd);
        bus.wb_we = we;
        bus.wb_rd = 5'(rd);
    endtask

    // One clock: check outputs mid-cycle against the model (plus optional
    // directed expectations, -1 = don't care), then advance the model.
    task automatic cyc(input int ws, input int wi, input int wf);
        bit raw, waw, e_stall, e_issue;
        int rs1, rs2, rd, wr;
        @(negedge clk);
        rs1 = int'(bus.ds_rs1);
        rs2 = int'(bus.ds_rs2);
        rd  = int'(bus.ds_rd);
        wr  = int'(bus.wb_rd);
        raw = (bus.ds_rs1_used && rs1 != 0 && m_cnt[rs1] > 0) ||
              (bus.ds_rs2_used && rs2 != 0 && m_cnt[rs2] > 0);
        waw = bus.ds_we && rd != 0 && m_cnt[rd] == CMAX;
        e_stall = bus.ds_valid && (raw || waw || m_flush);
        e_issue = bus.ds_valid && !e_stall && bus.ex_allow_in;
        if (chk_on) begin
            chk("ds_stall", 32'(bus.ds_stall), 32'(e_stall));
            chk("ds_issue", 32'(bus.ds_issue), 32'(e_issue));
            chk("fs_flush", 32'(bus.fs_flush), 32'(m_flush));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
            if (ws >= 0) chk("dir_stall", 32'(bus.ds_stall), 32'(ws));
            if (wi >= 0) chk("dir_issue", 32'(bus.ds_issue), 32'(wi));
            if (wf >= 0) chk("dir_flush", 32'(bus.fs_flush), 32'(wf));
        end
        $display("t=%0t rst=%0b v=%0b rs1=%0d/%0b rs2=%0d/%0b rd=%0d/%0b br=%0b al=%0b wb=%0b/%0d | stall=%0b issue=%0b flush=%0b sc=%0d",
                 $time, reset, bus.ds_valid, rs1, bus.ds_rs1_used, rs2, bus.ds_rs2_used, rd, bus.ds_we,
                 bus.ds_br_taken, bus.ex_allow_in, bus.wb_we, wr, bus.ds_stall, bus.ds_issue,
                 bus.fs_flush, stall_cycles);
        @(posedge clk);
        if (reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_flush = 1'b0;
            m_sc    = 0;
        end else begin
            bit do_inc, do_dec;
            do_inc = e_issue && bus.ds_we && rd != 0;
            do_dec = bus.wb_we && wr != 0 && m_cnt[wr] > 0;
            if (do_inc) m_cnt[rd]++;
            if (do_dec) m_cnt[wr]--;
            m_flush = e_issue && bus.ds_br_taken;
            if (e_stall && m_sc < PERF_MAX) m_sc++;
        end
        #1;
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_flush = 1'b0;
        m_sc    = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
        set_wb(0, 0);
        reset = 1'b1;
        cyc(-1, -1, -1);
        cyc(-1, -1, -1);
        reset  = 1'b0;
        chk_on = 1'b1;

        // Reset state: nothing pending, no flush, counter zero.
        cyc(0, 0, 0);
        chk("rst_sc", 32'(stall_cycles), 32'd0);
        set_id(1, 5, 1, 6, 1, 0, 0, 0, 1); cyc(0, 1, 0);

        // RAW on x5 held until the cycle after its retirement.
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 1); cyc(0, 1, 0);
        set_id(1, 5, 1, 0, 0, 0, 0, 0, 1); cyc(1, 0, 0);
        set_wb(1, 5);                      cyc(1, 0, 0);
        set_wb(0, 0);                      cyc(0, 1, 0);

        // Writes to x0 are never tracked.
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 1); cyc(0, 1, 0);
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 1); cyc(0, 1, 0);

        // WAW saturation on x7.
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 1);
        repeat (3) cyc(0, 1, 0);
        cyc(1, 0, 0);
        set_wb(1, 7); cyc(1, 0, 0);
        set_wb(0, 0); cyc(0, 1, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
        set_wb(1, 7);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 0, 0);                      // retirement at count 0 ignored
        set_wb(0, 0);
        set_id(1, 0, 0, 7, 1, 0, 0, 0, 1); cyc(0, 1, 0);
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 1); cyc(0, 1, 0);
        set_id(1, 0, 0, 7, 1, 0, 0, 0, 1); cyc(1, 0, 0);
        set_wb(1, 7);                      cyc(1, 0, 0);
        set_wb(0, 0);                      cyc(0, 1, 0);

        // Same-cycle issue and retire of x3 leaves count at 1.
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 1); cyc(0, 1, 0);
        set_wb(1, 3);                      cyc(0, 1, 0);
        set_id(1, 3, 1, 0, 0, 0, 0, 0, 1); cyc(1, 0, 0);
        set_wb(0, 0);                      cyc(0, 1, 0);

        // EX back-pressure alone neither stalls nor marks the scoreboard.
        set_id(1, 0, 0, 0, 0, 12, 1, 0, 0); cyc(0, 0, 0);
        set_id(1, 12, 1, 0, 0, 0, 0, 0, 1); cyc(0, 1, 0);

        // Taken branch: one flush cycle, held instruction does not issue.
        set_id(1, 0, 0, 0, 0, 0, 0, 1, 1); cyc(0, 1, 0);
        set_id(1, 0, 0, 0, 0, 9, 1, 1, 1); cyc(1, 0, 1);
        set_id(1, 9, 1, 0, 0, 0, 0, 0, 1); cyc(0, 1, 0);
        set_id(1, 0, 0, 0, 0, 0, 0, 1, 1); cyc(0, 1, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc(0, 0, 1);
        cyc(0, 0, 0);

        // Stall counter saturation, then reset discards counts.
        set_id(1, 0, 0, 0, 0, 10, 1, 0, 1); cyc(0, 1, 0);
        set_id(1, 10, 1, 0, 0, 0, 0, 0, 1);
        repeat ((1 << PERF_W) + 5) cyc(1, 0, 0);
        chk("sat_sc", 32'(stall_cycles), 32'(PERF_MAX));
        reset = 1'b1; cyc(-1, -1, -1);
        reset = 1'b0;
        chk("rst_sc2", 32'(stall_cycles), 32'd0);
        cyc(0, 1, 0);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 1);
        set_wb(1, 10); cyc(0, 0, 0);
        set_wb(0, 0);
        set_id(1, 0, 0, 0, 0, 10, 1, 0, 1); cyc(0, 1, 0);
        set_id(1, 10, 1, 0, 0, 0, 0, 0, 1); cyc(1, 0, 0);
        set_wb(1, 10);                      cyc(1, 0, 0);
        set_wb(0, 0);                       cyc(0, 1, 0);

        // Random traffic on a narrow register window to provoke hazards.
        for (int n = 0; n < 300; n++) begin
            set_id($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 1'($urandom),
                   int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)),
                   1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
            set_wb(1'($urandom), int'($urandom_range(0, 7)));
            cyc(-1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NREG, default 32, meaning architectural register count tracked by the scoreboard.
REQ-002 Parameter CNT_W, default 2, meaning per-register pending-write counter width; CNT_MAX = 2^CNT_W-1.
REQ-003 Parameter PERF_W, default 16, meaning stall-cycle counter width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ds_valid  input  1  ID stage holds a valid instruction.
REQ-007 ds_rs1, ds_rs2  input  5 each  ID source register indices.
REQ-008 ds_rs1_used, ds_rs2_used  input  1 each  source operand actually read.
REQ-009 ds_rd  input  5  ID destination index; ds_we  input  1  instruction writes rd.
REQ-010 ds_br_taken  input  1  ID-resolved branch/jump is taken.
REQ-011 ex_allow_in  input  1  ds_ex_reg can accept.
REQ-012 wb_rd  input  5; wb_we  input  1  retirement write to register file.
REQ-013 ds_stall  output  1  hold ID, block ds_to_ex_reg_valid.
REQ-014 ds_issue  output  1  instruction moves ID->EX this cycle.
REQ-015 fs_flush  output  1  invalidate fs_ds_reg contents (wrong-path).
REQ-016 stall_cycles  output  PERF_W  saturating count of ds_stall cycles.

Function
REQ-017 Scoreboard SHALL hold one CNT_W counter per register; entry 0 SHALL read 0 always.
REQ-018 raw_hazard SHALL be 1 when (ds_rs1_used & rs1!=0 & cnt[rs1]!=0) | (ds_rs2_used & rs2!=0 & cnt[rs2]!=0).
REQ-019 waw_full SHALL be 1 when ds_we & ds_rd!=0 & cnt[ds_rd]==CNT_MAX.
REQ-020 ds_stall SHALL equal ds_valid & (raw_hazard | waw_full | state==FLUSH), combinational from registered state.
REQ-021 ds_issue SHALL equal ds_valid & ~ds_stall & ex_allow_in.
REQ-022 On ds_issue & ds_we & ds_rd!=0, cnt[ds_rd] SHALL increment next edge.
REQ-023 On wb_we & wb_rd!=0 & cnt[wb_rd]!=0, cnt[wb_rd] SHALL decrement next edge; retirement with count 0 SHALL be ignored.
REQ-024 Simultaneous increment and decrement of the same register SHALL leave its count unchanged.
REQ-025 Hazard clears one cycle after retirement (no same-cycle WB bypass); the counter never wraps.
REQ-026 FSM states IDLE, FLUSH; IDLE->FLUSH on ds_issue & ds_br_taken; FLUSH->IDLE unconditionally next cycle.
REQ-027 fs_flush SHALL be 1 exactly while state==FLUSH; ds_br_taken in FLUSH SHALL be ignored.
REQ-028 An instruction held in ID during FLUSH SHALL not issue and SHALL not update the scoreboard.
REQ-029 stall_cycles SHALL increment each cycle ds_stall=1, saturating at all-ones.
REQ-030 ex_allow_in=0 alone SHALL not assert ds_stall.

Reset
REQ-031 On reset: all counts 0, state IDLE, stall_cycles 0; hence ds_stall=0, fs_flush=0 the following cycle.
REQ-032 Reset mid-operation SHALL discard in-flight counts; no retirement after reset reaches count<0.

Structure
REQ-033 State encoding (IDLE, FLUSH) and CNT_MAX SHALL live in the shared pipeline header package.
REQ-034 One sub-module pipe_scoreboard (counter array, inc/dec ports, two read ports) SHALL be instantiated; FSM and perf counter stay in pipe_ctrl.

Verification
REQ-035 Issue add x5 (we=1); next cycle ID reads rs1=x5 -> ds_stall=1 until the cycle after wb_we,wb_rd=5, then ds_issue=1.
REQ-036 Issue rd=x0 writes, then read x0 -> cnt stays 0, no stall.
REQ-037 Three issues writing x7 without retire -> fourth writer stalls (waw_full); one wb to x7 -> fourth issues next cycle.
REQ-038 Same-cycle issue rd=x3 and wb_rd=x3 with cnt[3]=1 -> cnt[3]=1 after edge.
REQ-039 ds_issue with ds_br_taken=1 -> fs_flush=1 for exactly 1 cycle, ID held that cycle, then IDLE.
REQ-040 Hold a RAW stall 2^PERF_W+5 cycles -> stall_cycles saturates at all-ones; reset -> 0 next cycle.
